dmem_arbiter: RTL and testbench

//  Shares the single data port of the RAM block between two bus masters: m0 = CPU data port,
//  m1 = DMA/peripheral master. Sits between the masters and the memory data port, alongside the

---
 rtl/dmem_arb_pkg.sv | 7 +
 rtl/dmem_arb_sat_ctr.sv | 35 +++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter and its bench.
package dmem_arb_pkg;

    typedef enum logic {ARB, LOCK} arb_state_t;
    typedef enum logic [1:0] {NONE, M0, M1} owner_t;

endpackage

// File: rtl/dmem_arb_sat_ctr.sv
// Saturating up-counter with clear, increment and terminal-value compare.
// clr and inc together load 1 (start of a new run that already counts one event).
module dmem_arb_sat_ctr #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign at_max = (cnt_q == WIDTH'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? WIDTH'(1) : '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the RAM data port: fixed m0 priority with m1 starvation guard, m1 lock.
// Define DMEM_ARB_RR_EN to replace the priority/starvation scheme with round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned LOCK_MAX   = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W/8-1:0] m0_we,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_gnt,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_rvalid,
    input  logic                m1_req,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W/8-1:0] m1_we,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_gnt,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_rvalid,
    input  logic                m1_lock,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t        state_q, state_d;
    owner_t            rd_owner_q, rd_owner_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              lock_clr, lock_inc, lock_at_max;
    logic              arb_cycle, m1_win;

    dmem_arb_sat_ctr #(
        .WIDTH (8),
        .MAX   (LOCK_MAX)
    ) u_lock_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (lock_clr),
        .inc     (lock_inc),
        .at_max  (lock_at_max)
    );

`ifdef DMEM_ARB_RR_EN
    owner_t last_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= M1;
        end else if (m0_gnt) begin
            last_q <= M0;
        end else if (m1_gnt) begin
            last_q <= M1;
        end
    end

    // Tie goes to whichever master did not win last.
    assign m1_win = m1_req && (!m0_req || (state_q == ARB && last_q == M0));
`else
    logic starve_at_max;

    // Starvation tracking only runs in ARB; it is frozen while m1 holds a lock.
    dmem_arb_sat_ctr #(
        .WIDTH (4),
        .MAX   (STARVE_MAX)
    ) u_starve_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state_q == ARB && m1_gnt),
        .inc     (state_q == ARB && m1_req && !m1_gnt),
        .at_max  (starve_at_max)
    );

    assign m1_win = m1_req && (!m0_req || (state_q == ARB && starve_at_max));
`endif

    // A LOCK cycle falls back to normal arbitration once m1 drops its request or the run expires.
    assign arb_cycle = (state_q == ARB) || !m1_req || lock_at_max;

    always_comb begin
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;
        state_d  = ARB;
        lock_clr = 1'b1;
        lock_inc = 1'b0;
        // Grants are held off while reset is asserted.
        if (reset_n) begin
            if (arb_cycle) begin
                m1_gnt = m1_win;
                m0_gnt = m0_req && !m1_win;
                if (m1_win && m1_lock) begin
                    state_d  = LOCK;
                    lock_inc = 1'b1;
                end
            end else begin
                m1_gnt = 1'b1;
                if (m1_lock) begin
                    state_d  = LOCK;
                    lock_clr = 1'b0;
                    lock_inc = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mem_addr   = addr_q;
        mem_we     = '0;
        mem_wdata  = wdata_q;
        rd_owner_d = NONE;
        if (m1_gnt) begin
            mem_addr  = m1_addr;
            mem_we    = m1_we;
            mem_wdata = m1_wdata;
            if (m1_we == '0) begin
                rd_owner_d = M1;
            end
        end else if (m0_gnt) begin
            mem_addr  = m0_addr;
            mem_we    = m0_we;
            mem_wdata = m0_wdata;
            if (m0_we == '0) begin
                rd_owner_d = M0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB;
            rd_owner_q <= NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
        end
    end

    assign m0_rvalid = (rd_owner_q == M0);
    assign m1_rvalid = (rd_owner_q == M1);
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised self-checking bench for dmem_arbiter against a cycle-level reference model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 4;
    localparam int LOCK_MAX   = 8;

    logic              clk, reset_n;
    logic              m0_req, m0_gnt, m0_rvalid;
    logic [ADDR_W-1:0] m0_addr;
    logic [1:0]        m0_we;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_gnt, m1_rvalid, m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [1:0]        m1_we;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_we;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX),
        .LOCK_MAX   (LOCK_MAX)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_we     (m0_we),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rdata  (m0_rdata),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_we     (m1_we),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rdata  (m1_rdata),
        .m1_rvalid (m1_rvalid),
        .m1_lock   (m1_lock),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the port: synchronous read, byte-enabled write.
    logic [DATA_W-1:0] env_mem [0:65535];
    always @(posedge clk) begin
        mem_rdata <= env_mem[mem_addr];
        if (mem_we[0]) env_mem[mem_addr][7:0]  <= mem_wdata[7:0];
        if (mem_we[1]) env_mem[mem_addr][15:8] <= mem_wdata[15:8];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [DATA_W-1:0] ref_mem [0:65535];
    int                starve, lock_run, last_m;
    owner_t            pend;
    logic [DATA_W-1:0] pend_data;
    logic [ADDR_W-1:0] ref_last_addr;
    int                tally0, tally1;

    task automatic model_reset();
        starve        = 0;
        lock_run      = 0;
        last_m        = 1;
        pend          = NONE;
        ref_last_addr = '0;
    endtask

    task automatic step(input logic r0, input logic [15:0] a0, input logic [1:0] w0,
                        input logic [15:0] d0, input logic r1, input logic [15:0] a1,
                        input logic [1:0] w1, input logic [15:0] d1, input logic lk);
        int                win;
        bit                in_lock;
        logic [15:0]       wa, wd;
        logic [1:0]        ww;
        m0_req = r0; m0_addr = a0; m0_we = w0; m0_wdata = d0;
        m1_req = r1; m1_addr = a1; m1_we = w1; m1_wdata = d1; m1_lock = lk;
        #4;
        in_lock = (lock_run > 0);
        if (in_lock && r1 && lock_run < LOCK_MAX) win = 1;
        else if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
            win = (!in_lock && last_m == 0) ? 1 : 0;
`else
            win = (!in_lock && starve >= STARVE_MAX) ? 1 : 0;
`endif
        end
        else if (r0) win = 0;
        else if (r1) win = 1;
        else win = -1;

        check_eq("m0_gnt", 32'(m0_gnt), 32'(win == 0));
        check_eq("m1_gnt", 32'(m1_gnt), 32'(win == 1));
        check_eq("m0_rvalid", 32'(m0_rvalid), 32'(pend == M0));
        check_eq("m1_rvalid", 32'(m1_rvalid), 32'(pend == M1));
        if (pend == M0) check_eq("m0_rdata", 32'(m0_rdata), 32'(pend_data));
        if (pend == M1) check_eq("m1_rdata", 32'(m1_rdata), 32'(pend_data));
        if (m0_gnt) tally0++;
        if (m1_gnt) tally1++;

        if (win < 0) begin
            check_eq("idle_we", 32'(mem_we), 32'(0));
            check_eq("idle_addr_hold", 32'(mem_addr), 32'(ref_last_addr));
            pend = NONE;
        end else begin
            wa = (win == 1) ? a1 : a0;
            ww = (win == 1) ? w1 : w0;
            wd = (win == 1) ? d1 : d0;
            check_eq("mem_addr", 32'(mem_addr), 32'(wa));
            check_eq("mem_we", 32'(mem_we), 32'(ww));
            if (ww != 2'b00) check_eq("mem_wdata", 32'(mem_wdata), 32'(wd));
            ref_last_addr = wa;
            if (ww == 2'b00) begin
                pend      = (win == 1) ? M1 : M0;
                pend_data = ref_mem[wa];
            end else begin
                pend = NONE;
                if (ww[0]) ref_mem[wa][7:0]  = wd[7:0];
                if (ww[1]) ref_mem[wa][15:8] = wd[15:8];
            end
        end

        if (!in_lock) begin
            if (win == 1) starve = 0;
            else if (r1 && starve < STARVE_MAX) starve++;
        end
        if (win == 1 && lk) lock_run = (in_lock && r1 && lock_run < LOCK_MAX) ? lock_run + 1 : 1;
        else lock_run = 0;
        if (win >= 0) last_m = win;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_addr = '0; m0_we = '0; m0_wdata = '0;
        m1_req = 0; m1_addr = '0; m1_we = '0; m1_wdata = '0; m1_lock = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int t;
        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        tally0 = 0;
        tally1 = 0;
        reset_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        #2;
        check_eq("rst_m0_gnt", 32'(m0_gnt), 32'(0));
        check_eq("rst_m1_gnt", 32'(m1_gnt), 32'(0));
        check_eq("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'(0));
        check_eq("rst_mem_we", 32'(mem_we), 32'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        // m0 streams writes then back-to-back reads, m1 idle
        for (int i = 0; i < 4; i++)
            step(1, 16'(16'h2000 + i), 2'b11, 16'(16'hA000 + i), 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(1, 16'(16'h2000 + i), 2'b00, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Both masters contend continuously from a fresh start
        do_reset();
        tally0 = 0;
        tally1 = 0;
        for (int i = 0; i < 10; i++)
            step(1, 16'h2004, 2'b00, 0, 1, 16'h2005, 2'b00, 0, 0);
`ifdef DMEM_ARB_RR_EN
        check_eq("t2_m1_gnts", 32'(tally1), 32'(5));
`else
        check_eq("t2_m1_gnts", 32'(tally1), 32'(2));
`endif

        // m1 locked burst, m0 joins after the first beat
        do_reset();
        tally0 = 0;
        tally1 = 0;
        step(0, 0, 0, 0, 1, 16'h2008, 2'b00, 0, 1);
        for (int i = 1; i < 8; i++)
            step(1, 16'h2009, 2'b00, 0, 1, 16'(16'h2008 + i), 2'b00, 0, 1);
        check_eq("t3_m1_burst", 32'(tally1), 32'(8));
        check_eq("t3_m0_blocked", 32'(tally0), 32'(0));
        step(1, 16'h2009, 2'b00, 0, 1, 16'h2010, 2'b00, 0, 1);
        check_eq("t3_m0_after", 32'(tally0), 32'(1));
        for (int i = 9; i < 20; i++)
            step(1, 16'h2009, 2'b00, 0, 1, 16'h2011, 2'b00, 0, 1);

        // Write by m0 observed by m1 read
        step(1, 16'h2010, 2'b11, 16'hBEEF, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 16'h2010, 2'b00, 0, 0);
        check_eq("t4_m1_rvalid", 32'(m1_rvalid), 32'(1));
        check_eq("t4_m1_rdata", 32'(m1_rdata), 32'(16'hBEEF));
        check_eq("t4_m0_rvalid", 32'(m0_rvalid), 32'(0));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset while a read result is pending
        step(1, 16'h2010, 2'b00, 0, 0, 0, 0, 0, 0);
        reset_n  = 1'b0;
        m1_req   = 1;
        m1_we    = 2'b11;
        m1_wdata = 16'h5555;
        #2;
        check_eq("t5_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'(0));
        check_eq("t5_gnt", 32'({m0_gnt, m1_gnt}), 32'(0));
        check_eq("t5_we", 32'(mem_we), 32'(0));
        @(posedge clk);
        #1;
        check_eq("t5_rvalid_hold", 32'({m0_rvalid, m1_rvalid}), 32'(0));
        check_eq("t5_gnt_hold", 32'({m0_gnt, m1_gnt}), 32'(0));
        reset_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic over a small address window
        for (int i = 0; i < 800; i++) begin
            t = int'($urandom_range(0, 99));
            step(t < 70, 16'(16'h2000 + $urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 1) ? 2'(($urandom_range(1, 3))) : 2'b00,
                 16'($urandom),
                 $urandom_range(0, 99) < 60, 16'(16'h2000 + $urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 1) ? 2'(($urandom_range(1, 3))) : 2'b00,
                 16'($urandom),
                 $urandom_range(0, 99) < 40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
